// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - multi-digit seven-segment driver with double-dabble BCD and hex modes
// Optional blink logic is compiled in when HEXDRV_BLINK_EN is defined.
module hex_display_driver #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_WIDTH  = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    mode_hex,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int ACC_W = 4 * ((BIN_WIDTH + 2) / 3) + 4;
  localparam int ACC_N = ACC_W / 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int DIG_W = 4 * NUM_DIGITS;
  localparam logic [31:0] DEC_LIMIT = 32'(10 ** NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] val_q;
  logic [BIN_WIDTH-1:0] shift_q;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_adj;
  logic [ACC_W-1:0]     acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hex_q;
  logic                 lz_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [SEG_W-1:0]     disp_q;
  logic [SEG_W-1:0]     disp_d;
  logic [DIG_W-1:0]     dig_hex;
  logic [DIG_W-1:0]     dig_dec;
  logic [DIG_W-1:0]     digits;
  logic                 seen_nz;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < ACC_N; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
    acc_d = ACC_W'({acc_adj, shift_q[BIN_WIDTH-1]});
  end

  always_comb begin
    dig_hex = DIG_W'(val_q);
    dig_dec = DIG_W'(acc_q);
    digits  = hex_q ? dig_hex : dig_dec;
    ovf_d   = hex_q ? ((val_q >> DIG_W) != '0) : (32'(val_q) >= DEC_LIMIT);
  end

  // Scan from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    disp_d  = '1;
    seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (digits[4*k +: 4] != 4'd0) seen_nz = 1'b1;
      if (ovf_d)                          disp_d[7*k +: 7] = SEG_DASH;
      else if (lz_q && !seen_nz && k != 0) disp_d[7*k +: 7] = SEG_BLANK;
      else                                 disp_d[7*k +: 7] = seg7(digits[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      lz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            val_q   <= value;
            shift_q <= value;
            hex_q   <= mode_hex;
            lz_q    <= lz_blank;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= mode_hex ? S_UPDATE : S_CONVERT;
          end
        end
        S_CONVERT: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          disp_q  <= disp_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef HEXDRV_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BL_W-1:0] blink_cnt_q;
  logic            phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign seg = (blink_en && !phase_q) ? '1 : disp_q;
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink_en;
  assign unused_blink_en = blink_en;
  assign seg = disp_q;
`endif

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - randomized self-checking bench for hex_display_driver
module tb_hex_display_driver;

  localparam int ND = 2;
  localparam int BW = 8;
  localparam int BD = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [BW-1:0] value;
  logic          mode_hex;
  logic          lz_blank;
  logic          blink_en;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [7*ND-1:0] seg;

  int errors = 0;
  int checks = 0;
  int edge_cnt;

  hex_display_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .mode_hex(mode_hex),
    .lz_blank(lz_blank), .blink_en(blink_en), .busy(busy), .done(done),
    .overflow(overflow), .seg(seg));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic bit model_ovf(input int v, input bit hex);
    return hex ? (v >= 16 ** ND) : (v >= 10 ** ND);
  endfunction

  function automatic logic [7*ND-1:0] model_seg(input int v, input bit hex, input bit lz);
    logic [7*ND-1:0] r;
    int base;
    int p;
    base = hex ? 16 : 10;
    p = 1;
    for (int k = 0; k < ND; k++) begin
      if (model_ovf(v, hex))        r[7*k +: 7] = DASH;
      else if (lz && k > 0 && v < p) r[7*k +: 7] = BLANK;
      else                           r[7*k +: 7] = SEG_TAB[(v / p) % base];
      p = p * base;
    end
    return r;
  endfunction

  task automatic run_load(input int v, input bit hex, input bit lz, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    value = BW'(v); mode_hex = hex; lz_blank = lz; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (seg !== '1)      begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, {7*ND{1'b1}}); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_decimal_42();
    int lat, bc;
    run_load(42, 0, 0, lat, bc);
    checks++; if (lat !== BW + 1) begin errors++; $display("FAIL dec42_latency: got %0d expected %0d", lat, BW + 1); end
    checks++; if (bc !== BW + 1)  begin errors++; $display("FAIL dec42_busy_cycles: got %0d expected %0d", bc, BW + 1); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL dec42_busy_at_done: got %b expected 0", busy); end
    checks++; if (seg !== {7'b0011001, 7'b0100100}) begin errors++; $display("FAIL dec42_seg: got %b expected %b", seg, {7'b0011001, 7'b0100100}); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dec42_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_lz_blank();
    int lat, bc;
    run_load(7, 0, 1, lat, bc);
    checks++; if (seg !== {BLANK, 7'b1111000}) begin errors++; $display("FAIL lz_7: got %b expected %b", seg, {BLANK, 7'b1111000}); end
    run_load(0, 0, 1, lat, bc);
    checks++; if (seg !== {BLANK, 7'b1000000}) begin errors++; $display("FAIL lz_0: got %b expected %b", seg, {BLANK, 7'b1000000}); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_load(100, 0, 1, lat, bc);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf100_flag: got %b expected 1", overflow); end
    checks++; if (seg !== {DASH, DASH}) begin errors++; $display("FAIL ovf100_seg: got %b expected %b", seg, {DASH, DASH}); end
    run_load(99, 0, 0, lat, bc);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf99_flag: got %b expected 0", overflow); end
    checks++; if (seg !== {7'b0010000, 7'b0010000}) begin errors++; $display("FAIL ovf99_seg: got %b expected %b", seg, {7'b0010000, 7'b0010000}); end
  endtask

  task automatic test_hex();
    int lat, bc;
    run_load(8'hAB, 1, 0, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL hexab_latency: got %0d expected 1", lat); end
    checks++; if (bc !== 1)  begin errors++; $display("FAIL hexab_busy_cycles: got %0d expected 1", bc); end
    checks++; if (seg !== {7'b0001000, 7'b0000011}) begin errors++; $display("FAIL hexab_seg: got %b expected %b", seg, {7'b0001000, 7'b0000011}); end
  endtask

  task automatic test_ignored_load();
    int n;
    bit extra_done;
    @(posedge clk); #1;
    value = 8'd57; mode_hex = 1'b0; lz_blank = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    value = 8'h12; mode_hex = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; mode_hex = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ignload_timeout: got done=%b expected 1", done); end
    checks++; if (seg !== model_seg(57, 0, 0)) begin errors++; $display("FAIL ignload_seg: got %b expected %b", seg, model_seg(57, 0, 0)); end
    extra_done = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) extra_done = 1'b1; end
    checks++; if (extra_done !== 1'b0) begin errors++; $display("FAIL ignload_extra_done: got %b expected 0", extra_done); end
    checks++; if (seg !== model_seg(57, 0, 0)) begin errors++; $display("FAIL ignload_seg_hold: got %b expected %b", seg, model_seg(57, 0, 0)); end
  endtask

  task automatic test_blink();
    int lat, bc;
    logic [7*ND-1:0] disp, exp_seg;
    run_load(42, 0, 0, lat, bc);
    disp = model_seg(42, 0, 0);
    blink_en = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
`ifdef HEXDRV_BLINK_EN
      exp_seg = (((edge_cnt / BD) % 2) == 0) ? disp : '1;
`else
      exp_seg = disp;
`endif
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL blink_cycle%0d: got %b expected %b", i, seg, exp_seg); end
    end
    blink_en = 1'b0;
    #1;
    checks++; if (seg !== disp) begin errors++; $display("FAIL blink_off: got %b expected %b", seg, disp); end
  endtask

  task automatic test_reset_mid_convert();
    int lat, bc;
    bit saw_done;
    @(posedge clk); #1;
    value = 8'd200; mode_hex = 1'b0; lz_blank = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (seg !== '1)    begin errors++; $display("FAIL midrst_seg: got %b expected all ones", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", saw_done); end
    checks++; if (seg !== '1) begin errors++; $display("FAIL midrst_seg_hold: got %b expected all ones", seg); end
    run_load(42, 0, 0, lat, bc);
    checks++; if (seg !== model_seg(42, 0, 0)) begin errors++; $display("FAIL midrst_reload: got %b expected %b", seg, model_seg(42, 0, 0)); end
    checks++; if (lat !== BW + 1) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, BW + 1); end
  endtask

  task automatic test_random();
    int v, lat, bc;
    bit hx, lz;
    for (int i = 0; i < 24; i++) begin
      v  = int'($urandom_range(0, 255));
      hx = 1'($urandom_range(0, 1));
      lz = 1'($urandom_range(0, 1));
      if (i < 4) v = i * 3;
      run_load(v, hx, lz, lat, bc);
      checks++; if (seg !== model_seg(v, hx, lz)) begin errors++; $display("FAIL rand_seg v=%0d hex=%0d lz=%0d: got %b expected %b", v, hx, lz, seg, model_seg(v, hx, lz)); end
      checks++; if (overflow !== model_ovf(v, hx)) begin errors++; $display("FAIL rand_ovf v=%0d hex=%0d: got %b expected %b", v, hx, overflow, model_ovf(v, hx)); end
      checks++; if (lat !== (hx ? 1 : BW + 1)) begin errors++; $display("FAIL rand_latency v=%0d hex=%0d: got %0d expected %0d", v, hx, lat, hx ? 1 : BW + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int v1, v2, lat, bc;
    v1 = int'($urandom_range(0, 99));
    v2 = int'($urandom_range(0, 99));
    run_load(v1, 0, 1, lat, bc);
    checks++; if (seg !== model_seg(v1, 0, 1)) begin errors++; $display("FAIL b2b_first: got %b expected %b", seg, model_seg(v1, 0, 1)); end
    run_load(v2, 0, 0, lat, bc);
    checks++; if (seg !== model_seg(v2, 0, 0)) begin errors++; $display("FAIL b2b_second: got %b expected %b", seg, model_seg(v2, 0, 0)); end
    checks++; if (lat !== BW + 1) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, BW + 1); end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; mode_hex = 1'b0; lz_blank = 1'b0; blink_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_decimal_42();
    test_lz_blank();
    test_overflow();
    test_hex();
    test_ignored_load();
    test_blink();
    test_reset_mid_convert();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
